// File: rtl/sdp_y_cfg_triosy_src_pkg.sv
// SDP Y-core shared definitions: FSM states and config bundle layout.
// Register file and HLS core both pack/unpack config through these offsets.
package sdp_y_cfg_triosy_src_pkg;

  localparam int CFG_W_DEF = 32;
  localparam int CNT_W_DEF = 8;

  localparam int ALU_SRC_LSB = 0;
  localparam int ALU_SRC_W   = 2;
  localparam int ALGO_LSB    = 2;
  localparam int ALGO_W      = 2;
  localparam int OP_LSB      = 4;
  localparam int OP_W        = 16;
  localparam int SHIFT_LSB   = 20;
  localparam int SHIFT_W     = 6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic [CFG_W_DEF-1:0] pack_cfg(
    input logic [ALU_SRC_W-1:0] alu_src,
    input logic [ALGO_W-1:0]    algo,
    input logic [OP_W-1:0]      op,
    input logic [SHIFT_W-1:0]   shift
  );
    logic [CFG_W_DEF-1:0] c;
    c = '0;
    c[ALU_SRC_LSB +: ALU_SRC_W] = alu_src;
    c[ALGO_LSB +: ALGO_W]       = algo;
    c[OP_LSB +: OP_W]           = op;
    c[SHIFT_LSB +: SHIFT_W]     = shift;
    return c;
  endfunction

endpackage

// File: rtl/sdp_y_cfg_dbuf.sv
// Active/shadow config register pair.
// load_act and swap never coincide with load_shd from the controlling FSM.
module sdp_y_cfg_dbuf #(
  parameter int W = 32
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         i_load_act,
  input  logic         i_load_shd,
  input  logic         i_swap,
  input  logic [W-1:0] i_cfg,
  output logic [W-1:0] o_act,
  output logic [W-1:0] o_shd,
  output logic         o_shd_vld
);

  logic [W-1:0] r_act;
  logic [W-1:0] r_shd;
  logic         r_shd_vld;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_act     <= '0;
      r_shd     <= '0;
      r_shd_vld <= 1'b0;
    end else begin
      if (i_load_act)
        r_act <= i_cfg;
      else if (i_swap)
        r_act <= r_shd;
      if (i_load_shd) begin
        r_shd     <= i_cfg;
        r_shd_vld <= 1'b1;
      end else if (i_swap) begin
        r_shd_vld <= 1'b0;
      end
    end
  end

  assign o_act     = r_act;
  assign o_shd     = r_shd;
  assign o_shd_vld = r_shd_vld;

endmodule

// File: rtl/sdp_y_cfg_triosy_src.sv
// Producer end of the SDP Y-core config trio-sync handshake.
// Holds a double-buffered config bundle until the core's triosy pulse.
module sdp_y_cfg_triosy_src
  import sdp_y_cfg_triosy_src_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             reg_op_en,
  input  logic [CFG_W-1:0] reg_cfg,
  output logic             reg_accept,
  output logic [CFG_W-1:0] core_cfg_dat,
  output logic             core_cfg_vz,
  input  logic             core_triosy_lz,
  output logic             layer_done,
  output logic [CNT_W-1:0] layer_cnt,
  output logic             busy,
  output logic             err_ovf,
  output logic             err_lz,
  input  logic             err_clr
);

  state_e r_state;
  state_e w_nxt;

  logic             w_load_act;
  logic             w_load_shd;
  logic             w_swap;
  logic             w_shd_vld;
  logic [CFG_W-1:0] w_act;
  logic [CFG_W-1:0] w_shd;
  logic             w_active;
  logic             w_lz_ok;
  logic             w_ovf_set;
  logic             w_lz_set;

  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_ovf;
  logic             r_err_lz;

  assign w_active  = (r_state == ST_ACTIVE);
  assign w_lz_ok   = core_triosy_lz & w_active;
  assign w_ovf_set = reg_op_en & w_shd_vld;
  assign w_lz_set  = core_triosy_lz & ~w_active;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      r_state <= ST_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_load_act = 1'b0;
    w_load_shd = 1'b0;
    w_swap     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (reg_op_en) begin
          w_load_act = 1'b1;
          w_nxt      = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Retire first; a full shadow forces the same-cycle op to be dropped.
        if (core_triosy_lz) begin
          if (w_shd_vld)
            w_swap = 1'b1;
          else if (reg_op_en)
            w_load_act = 1'b1;
          else
            w_nxt = ST_IDLE;
        end else if (reg_op_en && !w_shd_vld) begin
          w_load_shd = 1'b1;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  sdp_y_cfg_dbuf #(
    .W (CFG_W)
  ) u_dbuf (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .i_load_act      (w_load_act),
    .i_load_shd      (w_load_shd),
    .i_swap          (w_swap),
    .i_cfg           (reg_cfg),
    .o_act           (w_act),
    .o_shd           (w_shd),
    .o_shd_vld       (w_shd_vld)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_err_ovf <= 1'b0;
      r_err_lz  <= 1'b0;
    end else begin
      r_done    <= w_lz_ok;
      if (w_lz_ok)
        r_cnt <= r_cnt + CNT_W'(1);
      r_err_ovf <= w_ovf_set | (r_err_ovf & ~err_clr);
      r_err_lz  <= w_lz_set | (r_err_lz & ~err_clr);
    end
  end

  logic w_shd_unused;
  assign w_shd_unused = ^w_shd;

  assign reg_accept   = ~w_shd_vld;
  assign core_cfg_vz  = w_active;
  assign core_cfg_dat = w_act;
  assign layer_done   = r_done;
  assign layer_cnt    = r_cnt;
  assign busy         = w_active | w_shd_vld;
  assign err_ovf      = r_err_ovf;
  assign err_lz       = r_err_lz;

endmodule

// File: tb/tb_sdp_y_cfg_triosy_src.sv
// Bench for sdp_y_cfg_triosy_src: directed table, corner sequences and
// random traffic checked against a queue-based layer model.
module tb_sdp_y_cfg_triosy_src;

  logic        clk;
  logic        rstn;
  logic        reg_op_en;
  logic [31:0] reg_cfg;
  logic        reg_accept;
  logic [31:0] core_cfg_dat;
  logic        core_cfg_vz;
  logic        core_triosy_lz;
  logic        layer_done;
  logic [7:0]  layer_cnt;
  logic        busy;
  logic        err_ovf;
  logic        err_lz;
  logic        err_clr;

  int n_chk;
  int n_err;

  sdp_y_cfg_triosy_src #(.CFG_W(32), .CNT_W(8)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .reg_op_en       (reg_op_en),
    .reg_cfg         (reg_cfg),
    .reg_accept      (reg_accept),
    .core_cfg_dat    (core_cfg_dat),
    .core_cfg_vz     (core_cfg_vz),
    .core_triosy_lz  (core_triosy_lz),
    .layer_done      (layer_done),
    .layer_cnt       (layer_cnt),
    .busy            (busy),
    .err_ovf         (err_ovf),
    .err_lz          (err_lz),
    .err_clr         (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue of pending layer configs, head is the one the core sees.
  logic [31:0] mq[$];
  logic [31:0] m_dat;
  logic [7:0]  m_cnt;
  logic        m_done;
  logic        m_ovf;
  logic        m_elz;

  task automatic model_reset();
    mq.delete();
    m_dat  = '0;
    m_cnt  = '0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_elz  = 1'b0;
  endtask

  task automatic model_step(input logic op, input logic [31:0] cfg,
                            input logic lz, input logic clr);
    int  n;
    bit  room;
    n      = mq.size();
    room   = (n < 2);
    m_done = lz && (n > 0);
    if (lz && n > 0) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 8'd1;
    end
    if (op && room)
      mq.push_back(cfg);
    if (mq.size() > 0)
      m_dat = mq[0];
    m_ovf = (op && !room) || (m_ovf && !clr);
    m_elz = (lz && n == 0) || (m_elz && !clr);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m.vz",   32'(core_cfg_vz), 32'(mq.size() > 0));
    chk("m.dat",  core_cfg_dat,     m_dat);
    chk("m.done", 32'(layer_done),  32'(m_done));
    chk("m.cnt",  32'(layer_cnt),   32'(m_cnt));
    chk("m.ovf",  32'(err_ovf),     32'(m_ovf));
    chk("m.elz",  32'(err_lz),      32'(m_elz));
    chk("m.acc",  32'(reg_accept),  32'(mq.size() < 2));
    chk("m.busy", 32'(busy),        32'(mq.size() > 0));
  endtask

  task automatic cyc(input logic op, input logic [31:0] cfg,
                     input logic lz, input logic clr);
    @(negedge clk);
    reg_op_en      = op;
    reg_cfg        = cfg;
    core_triosy_lz = lz;
    err_clr        = clr;
    @(posedge clk);
    #1;
    model_step(op, cfg, lz, clr);
    chk_model();
  endtask

  typedef struct {
    logic        op;
    logic [31:0] cfg;
    logic        lz;
    logic        clr;
    logic        vz;
    logic [31:0] dat;
    logic        done;
    logic [7:0]  cnt;
    logic        ovf;
    logic        elz;
    logic        acc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    n_chk          = 0;
    n_err          = 0;
    rstn           = 1'b0;
    reg_op_en      = 1'b0;
    reg_cfg        = '0;
    core_triosy_lz = 1'b0;
    err_clr        = 1'b0;
    model_reset();

    //          op cfg     lz clr  vz dat     done cnt ovf elz acc
    tbl[0]  = '{1, 32'hA5, 0, 0,   1, 32'hA5, 0,   0,  0,  0,  1};
    tbl[1]  = '{0, 32'h0,  0, 0,   1, 32'hA5, 0,   0,  0,  0,  1};
    tbl[2]  = '{0, 32'h0,  1, 0,   0, 32'hA5, 1,   1,  0,  0,  1};
    tbl[3]  = '{1, 32'h11, 0, 0,   1, 32'h11, 0,   1,  0,  0,  1};
    tbl[4]  = '{1, 32'h22, 0, 0,   1, 32'h11, 0,   1,  0,  0,  0};
    tbl[5]  = '{0, 32'h0,  1, 0,   1, 32'h22, 1,   2,  0,  0,  1};
    tbl[6]  = '{0, 32'h0,  1, 0,   0, 32'h22, 1,   3,  0,  0,  1};
    tbl[7]  = '{1, 32'h30, 0, 0,   1, 32'h30, 0,   3,  0,  0,  1};
    tbl[8]  = '{1, 32'h33, 1, 0,   1, 32'h33, 1,   4,  0,  0,  1};
    tbl[9]  = '{1, 32'h40, 0, 0,   1, 32'h33, 0,   4,  0,  0,  0};
    tbl[10] = '{1, 32'h44, 0, 0,   1, 32'h33, 0,   4,  1,  0,  0};
    tbl[11] = '{0, 32'h0,  1, 0,   1, 32'h40, 1,   5,  1,  0,  1};
    tbl[12] = '{0, 32'h0,  0, 1,   1, 32'h40, 0,   5,  0,  0,  1};
    tbl[13] = '{0, 32'h0,  1, 0,   0, 32'h40, 1,   6,  0,  0,  1};
    tbl[14] = '{0, 32'h0,  1, 0,   0, 32'h40, 0,   6,  0,  1,  1};
    tbl[15] = '{0, 32'h0,  1, 1,   0, 32'h40, 0,   6,  0,  1,  1};
    tbl[16] = '{0, 32'h0,  0, 1,   0, 32'h40, 0,   6,  0,  0,  1};

    #1;
    chk("rst.vz",   32'(core_cfg_vz), 32'd0);
    chk("rst.dat",  core_cfg_dat,     32'd0);
    chk("rst.cnt",  32'(layer_cnt),   32'd0);
    chk("rst.acc",  32'(reg_accept),  32'd1);
    chk("rst.busy", 32'(busy),        32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].op, tbl[i].cfg, tbl[i].lz, tbl[i].clr);
      chk($sformatf("tbl%0d.vz", i),   32'(core_cfg_vz), 32'(tbl[i].vz));
      chk($sformatf("tbl%0d.dat", i),  core_cfg_dat,     tbl[i].dat);
      chk($sformatf("tbl%0d.done", i), 32'(layer_done),  32'(tbl[i].done));
      chk($sformatf("tbl%0d.cnt", i),  32'(layer_cnt),   32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.ovf", i),  32'(err_ovf),     32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.elz", i),  32'(err_lz),      32'(tbl[i].elz));
      chk($sformatf("tbl%0d.acc", i),  32'(reg_accept),  32'(tbl[i].acc));
    end

    // Counter wrap: bypass back-to-back layers from count 6 up to 255.
    cyc(1, 32'h100, 0, 0);
    for (int i = 0; i < 249; i++)
      cyc(1, 32'h200 + 32'(i), 1, 0);
    chk("wrap.pre", 32'(layer_cnt), 32'd255);
    chk("wrap.vz",  32'(core_cfg_vz), 32'd1);
    cyc(0, 32'h0, 1, 0);
    chk("wrap.cnt",  32'(layer_cnt),  32'd0);
    chk("wrap.done", 32'(layer_done), 32'd1);

    // Async reset mid-layer with shadow full and a sticky error set.
    cyc(1, 32'h50, 0, 0);
    cyc(1, 32'h55, 1, 0);
    cyc(1, 32'h66, 0, 0);
    cyc(1, 32'h77, 0, 0);
    chk("pre.ovf", 32'(err_ovf), 32'd1);
    chk("pre.cnt", 32'(layer_cnt), 32'd1);
    @(negedge clk);
    reg_op_en = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst.vz",   32'(core_cfg_vz), 32'd0);
    chk("arst.dat",  core_cfg_dat,     32'd0);
    chk("arst.cnt",  32'(layer_cnt),   32'd0);
    chk("arst.ovf",  32'(err_ovf),     32'd0);
    chk("arst.busy", 32'(busy),        32'd0);
    chk("arst.acc",  32'(reg_accept),  32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(0, 32'h0, 0, 0);
    chk("post.vz",   32'(core_cfg_vz), 32'd0);
    chk("post.done", 32'(layer_done),  32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 35, $urandom(),
          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 6);

    @(negedge clk);
    reg_op_en      = 1'b0;
    core_triosy_lz = 1'b0;
    err_clr        = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sdp_y_cfg_triosy_src.md
Name: sdp_y_cfg_triosy_src

Overview:
- Producer end of the SDP Y-core config trio-sync handshake.
- Takes per-layer config snapshots from the SDP register file and presents them to the HLS core as a stable bundle with a valid (vz).
- Holds each snapshot until the core returns its triosy completion pulse (lz), then retires it.
- Double-buffered: active + shadow, so the register file can program the next layer while the current one runs.

Parameters:
- CFG_W, 32, width of config bundle (alu_src/algo/op/shift packed by register file).
- CNT_W, 8, width of completed-layer counter.

Ports:
- nvdla_core_clk  input  1  clock.
- nvdla_core_rstn  input  1  reset, asynchronous, active-low.
- reg_op_en  input  1  one-cycle layer-start pulse from register file.
- reg_cfg  input  CFG_W  config snapshot, sampled when reg_op_en & reg_accept.
- reg_accept  output  1  combinational; 1 when a snapshot can be taken this cycle.
- core_cfg_dat  output  CFG_W  config presented to core.
- core_cfg_vz  output  1  config valid to core.
- core_triosy_lz  input  1  one-cycle pulse from core: current config consumed, layer done.
- layer_done  output  1  registered one-cycle pulse, one cycle after an accepted lz.
- layer_cnt  output  CNT_W  completed-layer count, wraps.
- busy  output  1  state==ACTIVE or shadow_vld.
- err_ovf  output  1  sticky: reg_op_en seen while reg_accept=0.
- err_lz  output  1  sticky: lz seen while core_cfg_vz=0.
- err_clr  input  1  clears both sticky errors.

Behaviour:
- State machine, states IDLE and ACTIVE; registers active_cfg, shadow_cfg, shadow_vld.
- Reset (async, rstn=0): state=IDLE, core_cfg_vz=0, core_cfg_dat=0, shadow_cfg=0, shadow_vld=0, layer_done=0, layer_cnt=0, err_ovf=0, err_lz=0. Reset mid-layer discards both buffers; no layer_done is generated.
- reg_accept = !shadow_vld. It is always 1 in IDLE.
- core_cfg_vz = (state==ACTIVE). core_cfg_dat = active_cfg, which is constant while vz=1 except on a swap edge.
- IDLE, reg_op_en:
  - active_cfg <= reg_cfg; state <= ACTIVE.
  - vz rises on the next cycle (latency 1).
- ACTIVE, reg_op_en with reg_accept=1 and no lz:
  - shadow_cfg <= reg_cfg; shadow_vld <= 1.
- ACTIVE, lz:
  - layer_done=1 next cycle; layer_cnt += 1 (mod 2^CNT_W, 2^CNT_W-1 -> 0).
  - Then, in priority:
    - (a) shadow_vld=1: active_cfg <= shadow_cfg; shadow_vld <= 0; stay ACTIVE. vz stays 1 with no bubble. A same-cycle reg_op_en is accepted only if reg_accept was 1, which it is not here, so it is rejected and sets err_ovf.
    - (b) shadow empty and reg_op_en: active_cfg <= reg_cfg (bypass); stay ACTIVE; vz stays 1.
    - (c) otherwise: state <= IDLE; vz drops next cycle; active_cfg retains its value.
- IDLE, lz: ignored (no count, no layer_done); err_lz <= 1.
- reg_op_en with reg_accept=0: snapshot dropped; err_ovf <= 1; existing buffers are untouched.
- err_clr: clears both errors next cycle. If err_clr coincides with a new error event, the set wins.
- Back-to-back lz pulses on consecutive cycles are each honoured: a pending shadow is swapped on the first; the second retires it.
- Only edges are registered. No combinational path from core_triosy_lz to any output except via flops.

Decomposition:
- Shared SDP Y-core package holds:
  - state enum {IDLE, ACTIVE};
  - field offsets/widths for packing alu_src/algo/op/shift into CFG_W, so register file and core agree.
- One natural sub-module: sdp_y_cfg_dbuf (active/shadow register pair with load/swap/bypass controls).
- FSM, counter and error flags stay in the top.

Test Plan:
- Reset then reg_op_en with reg_cfg=0x0000_00A5 -> vz=1 and dat=0xA5 next cycle. lz 10 cycles later -> layer_done pulse, layer_cnt=1, vz=0 the cycle after.
- Program A=0x11; while ACTIVE program B=0x22 -> reg_accept drops. lz -> dat=0x22 with vz held at 1 (no bubble), layer_cnt=1. Second lz -> IDLE, layer_cnt=2.
- ACTIVE, shadow empty, lz and reg_op_en (0x33) in the same cycle -> dat=0x33, vz stays 1, err_ovf=0.
- ACTIVE with shadow full, extra reg_op_en (0x44) -> err_ovf=1, shadow keeps the old value. err_clr -> err_ovf=0 next cycle.
- lz while IDLE -> err_lz=1, layer_cnt unchanged, no layer_done.
- Preset 255 completions (CNT_W=8), one more lz -> layer_cnt=0. Assert rstn low mid-layer with shadow full -> all outputs 0 immediately (async); after release, vz stays 0 until a new reg_op_en.
